// File: rtl/sc_gamesequencer_pkg.sv
// Shared game-state constants for the sequencer and the level counter.
package sc_gamesequencer_pkg;

   localparam int STATE_DATAWIDTH = 2;
   localparam int LEVEL_DATAWIDTH = 3;

   // Public game-state code carried on the state bus; code 3 is never driven.
   typedef enum logic [STATE_DATAWIDTH-1:0] {
      AWAITSTART = 2'd0,
      STARTGAME  = 2'd1,
      ENDGAME    = 2'd2
   } game_state_e;

endpackage

// File: rtl/sc_gamesequencer_btnsync.sv
// Start-button conditioner: 2-flop synchronizer followed by a registered
// falling-edge detector, giving one press_o cycle per button press.
module sc_gamesequencer_btnsync (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_n_i,
   output logic press_o
);

   logic sync1_q, sync2_q, prev_q, press_q;
   logic press_d;

   // A press is a 1 -> 0 transition of the synchronized (active-low) button.
   assign press_d = prev_q & ~sync2_q;

   // Synchronizer, edge history and registered press pulse; reset means "released".
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         press_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample its pre-edge input,
         // so the chain shifts by one stage per clock instead of collapsing.
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/sc_gamesequencer.sv
// Game-flow sequencer: owns lives, the respawn hold-off and the public
// game-state code; emits level-advance and frog-reset pulses. All outputs registered.
module sc_gamesequencer #(
   parameter int STATE_DATAWIDTH = sc_gamesequencer_pkg::STATE_DATAWIDTH,
   parameter int LEVEL_DATAWIDTH = sc_gamesequencer_pkg::LEVEL_DATAWIDTH,
   parameter int LIVES_DATAWIDTH = 2,
   parameter int INIT_LIVES      = 3,
   parameter int MAX_LEVEL       = 4,
   parameter int HOLDOFF_CYCLES  = 50000000
) (
   input  logic                       SC_GAMESEQ_CLOCK_50,
   input  logic                       SC_GAMESEQ_RESET_InLow,
   input  logic                       SC_GAMESEQ_Start_InLow,
   input  logic                       SC_GAMESEQ_FrogAtGoal_InHigh,
   input  logic                       SC_GAMESEQ_Collision_InHigh,
   input  logic [LEVEL_DATAWIDTH-1:0] SC_GAMESEQ_Level_InBus,
   output logic [STATE_DATAWIDTH-1:0] SC_GAMESEQ_CurrentState_OutBus,
   output logic                       SC_GAMESEQ_LevelUp_OutLow,
   output logic [LIVES_DATAWIDTH-1:0] SC_GAMESEQ_Lives_OutBus,
   output logic                       SC_GAMESEQ_FrogReset_OutHigh,
   output logic                       SC_GAMESEQ_Win_OutHigh
);

   import sc_gamesequencer_pkg::*;

   localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   // HOLDOFF shares the public code of PLAY; the split is internal only.
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLDOFF, S_OVER} fsm_e;

   fsm_e                       state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [LIVES_DATAWIDTH-1:0] lives_q, lives_d;
   logic                       win_q, win_d;
   logic                       level_up_n_q, level_up_n_d;
   logic                       frog_reset_q, frog_reset_d;
   logic [STATE_DATAWIDTH-1:0] state_code_q, state_code_d;
   logic                       goal_q, goal_prev_q, hit_q, hit_prev_q;
   logic                       start_press, goal_evt, hit_evt;

   sc_gamesequencer_btnsync u_btnsync (
      .clk_i   (SC_GAMESEQ_CLOCK_50),
      .rst_n_i (SC_GAMESEQ_RESET_InLow),
      .btn_n_i (SC_GAMESEQ_Start_InLow),
      .press_o (start_press)
   );

   // Register goal/collision levels and keep one cycle of history for edge detection.
   always_ff @(posedge SC_GAMESEQ_CLOCK_50 or negedge SC_GAMESEQ_RESET_InLow) begin
      if (!SC_GAMESEQ_RESET_InLow) begin
         goal_q      <= 1'b0;
         goal_prev_q <= 1'b0;
         hit_q       <= 1'b0;
         hit_prev_q  <= 1'b0;
      end else begin
         goal_q      <= SC_GAMESEQ_FrogAtGoal_InHigh;
         goal_prev_q <= goal_q;
         hit_q       <= SC_GAMESEQ_Collision_InHigh;
         hit_prev_q  <= hit_q;
      end
   end

   // A level held high fires once; it must drop before it can fire again.
   assign goal_evt = goal_q & ~goal_prev_q;
   assign hit_evt  = hit_q & ~hit_prev_q;

   // Next-state, lives, hold-off counter and output pulses.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      lives_d      = lives_q;
      win_d        = win_q;
      level_up_n_d = 1'b1;
      frog_reset_d = 1'b0;
      state_code_d = STATE_DATAWIDTH'(AWAITSTART);

      case (state_q)
         S_IDLE: begin
            if (start_press) begin
               state_d      = S_PLAY;
               lives_d      = LIVES_DATAWIDTH'(INIT_LIVES);
               win_d        = 1'b0;
               frog_reset_d = 1'b1;
            end
         end
         S_PLAY: begin
            // Collision takes priority over a simultaneous goal.
            if (hit_evt) begin
               if (lives_q <= LIVES_DATAWIDTH'(1)) begin
                  state_d = S_OVER;
                  lives_d = '0;
                  win_d   = 1'b0;
               end else begin
                  state_d      = S_HOLDOFF;
                  lives_d      = lives_q - LIVES_DATAWIDTH'(1);
                  frog_reset_d = 1'b1;
                  cnt_d        = '0;
               end
            end else if (goal_evt) begin
               if (SC_GAMESEQ_Level_InBus == LEVEL_DATAWIDTH'(MAX_LEVEL - 1)) begin
                  state_d = S_OVER;
                  win_d   = 1'b1;
               end else begin
                  level_up_n_d = 1'b0;
                  frog_reset_d = 1'b1;
               end
            end
         end
         S_HOLDOFF: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_PLAY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_OVER: begin
            if (start_press) begin
               state_d = S_IDLE;
               lives_d = '0;
               win_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_PLAY, S_HOLDOFF: state_code_d = STATE_DATAWIDTH'(STARTGAME);
         S_OVER:            state_code_d = STATE_DATAWIDTH'(ENDGAME);
         default:           state_code_d = STATE_DATAWIDTH'(AWAITSTART);
      endcase
   end

   // State and output registers; reset drops any pending pulse.
   always_ff @(posedge SC_GAMESEQ_CLOCK_50 or negedge SC_GAMESEQ_RESET_InLow) begin
      if (!SC_GAMESEQ_RESET_InLow) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         lives_q      <= '0;
         win_q        <= 1'b0;
         level_up_n_q <= 1'b1;
         frog_reset_q <= 1'b0;
         state_code_q <= STATE_DATAWIDTH'(AWAITSTART);
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lives_q      <= lives_d;
         win_q        <= win_d;
         level_up_n_q <= level_up_n_d;
         frog_reset_q <= frog_reset_d;
         state_code_q <= state_code_d;
      end
   end

   assign SC_GAMESEQ_CurrentState_OutBus = state_code_q;
   assign SC_GAMESEQ_LevelUp_OutLow      = level_up_n_q;
   assign SC_GAMESEQ_Lives_OutBus        = lives_q;
   assign SC_GAMESEQ_FrogReset_OutHigh   = frog_reset_q;
   assign SC_GAMESEQ_Win_OutHigh         = win_q;

endmodule

// File: tb/tb_sc_gamesequencer.sv
// Self-checking bench for sc_gamesequencer: per-cycle vectors with a
// scoreboard queue, plus hand sequences for hold-off, priority and reset.
module tb_sc_gamesequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_n = 1'b1;
   logic       goal = 1'b0;
   logic       hit = 1'b0;
   logic [2:0] level = 3'd0;
   logic [1:0] st, lives;
   logic       lu_n, fr, win;

   int n_cmp  = 0;
   int n_fail = 0;
   int row_no = 0;

   always #5 clk = ~clk;

   sc_gamesequencer #(.HOLDOFF_CYCLES(8)) dut (
      .SC_GAMESEQ_CLOCK_50            (clk),
      .SC_GAMESEQ_RESET_InLow         (rst_n),
      .SC_GAMESEQ_Start_InLow         (start_n),
      .SC_GAMESEQ_FrogAtGoal_InHigh   (goal),
      .SC_GAMESEQ_Collision_InHigh    (hit),
      .SC_GAMESEQ_Level_InBus         (level),
      .SC_GAMESEQ_CurrentState_OutBus (st),
      .SC_GAMESEQ_LevelUp_OutLow      (lu_n),
      .SC_GAMESEQ_Lives_OutBus        (lives),
      .SC_GAMESEQ_FrogReset_OutHigh   (fr),
      .SC_GAMESEQ_Win_OutHigh         (win)
   );

   // One cycle of stimulus and the outputs expected after that cycle's edge.
   typedef struct {
      logic       start_n;
      logic       goal;
      logic       hit;
      logic [2:0] level;
      logic [1:0] st;
      logic       lu_n;
      logic [1:0] lives;
      logic       fr;
      logic       win;
   } vec_t;

   vec_t tbl [25];
   vec_t exp_q [$];

   function automatic vec_t v(input logic s, input logic g, input logic h, input logic [2:0] l,
                              input logic [1:0] e_st, input logic e_lu, input logic [1:0] e_lv,
                              input logic e_fr, input logic e_win);
      vec_t r;
      r.start_n = s; r.goal = g; r.hit = h; r.level = l;
      r.st = e_st; r.lu_n = e_lu; r.lives = e_lv; r.fr = e_fr; r.win = e_win;
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Drive one row, queue its expectation, and compare once the edge has passed.
   task automatic step(input vec_t t, input string tag);
      vec_t e;
      start_n = t.start_n;
      goal    = t.goal;
      hit     = t.hit;
      level   = t.level;
      exp_q.push_back(t);
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      row_no++;
      check($sformatf("%s[%0d].state", tag, row_no), {6'd0, st}, {6'd0, e.st});
      check($sformatf("%s[%0d].levelup_n", tag, row_no), {7'd0, lu_n}, {7'd0, e.lu_n});
      check($sformatf("%s[%0d].lives", tag, row_no), {6'd0, lives}, {6'd0, e.lives});
      check($sformatf("%s[%0d].frogreset", tag, row_no), {7'd0, fr}, {7'd0, e.fr});
      check($sformatf("%s[%0d].win", tag, row_no), {7'd0, win}, {7'd0, e.win});
   endtask

   // Start press: low for two cycles, state reacts on the fourth edge.
   task automatic press(input logic [1:0] st0, input logic [1:0] lv0, input logic w0,
                        input logic [1:0] st1, input logic [1:0] lv1, input logic fr1,
                        input string tag);
      step(v(0, 0, 0, 0, st0, 1, lv0, 0, w0), tag);
      step(v(0, 0, 0, 0, st0, 1, lv0, 0, w0), tag);
      step(v(1, 0, 0, 0, st0, 1, lv0, 0, w0), tag);
      step(v(1, 0, 0, 0, st1, 1, lv1, fr1, 1'b0), tag);
   endtask

   initial begin
      // start press, goal on level 1 held, final goal on level 3, restart
      tbl[0]  = v(0, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[1]  = v(0, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[2]  = v(1, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[3]  = v(1, 0, 0, 0, 1, 1, 3, 1, 0);
      tbl[4]  = v(1, 0, 0, 0, 1, 1, 3, 0, 0);
      tbl[5]  = v(1, 1, 0, 1, 1, 1, 3, 0, 0);
      tbl[6]  = v(1, 1, 0, 1, 1, 0, 3, 1, 0);
      for (int i = 7; i <= 15; i++) tbl[i] = v(1, 1, 0, 1, 1, 1, 3, 0, 0);
      tbl[16] = v(1, 0, 0, 1, 1, 1, 3, 0, 0);
      tbl[17] = v(1, 1, 0, 3, 1, 1, 3, 0, 0);
      tbl[18] = v(1, 1, 0, 3, 2, 1, 3, 0, 1);
      tbl[19] = v(1, 0, 0, 3, 2, 1, 3, 0, 1);
      tbl[20] = v(0, 0, 0, 3, 2, 1, 3, 0, 1);
      tbl[21] = v(0, 0, 0, 3, 2, 1, 3, 0, 1);
      tbl[22] = v(1, 0, 0, 3, 2, 1, 3, 0, 1);
      tbl[23] = v(1, 0, 0, 3, 0, 1, 0, 0, 0);
      tbl[24] = v(1, 0, 0, 0, 0, 1, 0, 0, 0);

      // reset values while reset is held
      repeat (2) @(negedge clk);
      check("reset.state", {6'd0, st}, 8'd0);
      check("reset.levelup_n", {7'd0, lu_n}, 8'd1);
      check("reset.lives", {6'd0, lives}, 8'd0);
      check("reset.frogreset", {7'd0, fr}, 8'd0);
      check("reset.win", {7'd0, win}, 8'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 25; i++) step(tbl[i], "vec");

      // three collisions with an 8-cycle hold-off, then restart
      press(0, 0, 0, 1, 3, 1, "start2");
      step(v(1, 0, 1, 0, 1, 1, 3, 0, 0), "hit1");
      step(v(1, 0, 0, 0, 1, 1, 2, 1, 0), "hit1");
      for (int i = 2; i <= 9; i++) step(v(1, 0, (i == 3 || i == 9), 0, 1, 1, 2, 0, 0), "hold1");
      step(v(1, 0, 0, 0, 1, 1, 1, 1, 0), "hit2");
      for (int i = 2; i <= 10; i++) step(v(1, 0, (i == 8 || i == 10), 0, 1, 1, 1, 0, 0), "hold2");
      step(v(1, 0, 0, 0, 2, 1, 0, 0, 0), "hit3");
      press(2, 0, 0, 0, 0, 0, "restart");

      // goal and collision rising together: collision wins
      press(0, 0, 0, 1, 3, 1, "start3");
      step(v(1, 0, 1, 0, 1, 1, 3, 0, 0), "hitA");
      step(v(1, 0, 0, 0, 1, 1, 2, 1, 0), "hitA");
      for (int i = 2; i <= 8; i++) step(v(1, 0, 0, 0, 1, 1, 2, 0, 0), "holdA");
      step(v(1, 1, 1, 1, 1, 1, 2, 0, 0), "both");
      step(v(1, 0, 0, 1, 1, 1, 1, 1, 0), "both");
      for (int i = 2; i <= 9; i++) step(v(1, 0, 0, 1, 1, 1, 1, 0, 0), "holdB");
      step(v(1, 1, 0, 1, 1, 1, 1, 0, 0), "goalpend");

      // asynchronous reset with a goal pulse pending
      #2 rst_n = 1'b0;
      #1;
      check("midreset.state", {6'd0, st}, 8'd0);
      check("midreset.levelup_n", {7'd0, lu_n}, 8'd1);
      check("midreset.lives", {6'd0, lives}, 8'd0);
      check("midreset.frogreset", {7'd0, fr}, 8'd0);
      check("midreset.win", {7'd0, win}, 8'd0);
      goal = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midreset.pulse_dropped", {7'd0, lu_n}, 8'd1);
      check("midreset.state_held", {6'd0, st}, 8'd0);
      rst_n = 1'b1;
      step(v(1, 0, 0, 0, 0, 1, 0, 0, 0), "postreset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sc_gamesequencer.md
# sc_gamesequencer

Game-flow sequencer that drives the game-state bus and the active-low level-advance pulse consumed by the level counter. It sits between the player/board inputs (start button, frog-at-goal, collision) and the scoring/level logic, and owns lives and the respawn hold-off. All outputs are registered; it is the single source of the 2-bit game-state code used across the design.

## Interface

- STATE_DATAWIDTH, 2, width of game-state bus
- LEVEL_DATAWIDTH, 3, width of level feedback bus
- LIVES_DATAWIDTH, 2, width of lives counter
- INIT_LIVES, 3, lives loaded at game start
- MAX_LEVEL, 4, number of levels; reaching the goal on level MAX_LEVEL-1 ends the game
- HOLDOFF_CYCLES, 50000000, respawn hold-off after a collision (1 s at 50 MHz)

- SC_GAMESEQ_CLOCK_50  in  1  system clock, 50 MHz, single clock domain
- SC_GAMESEQ_RESET_InLow  in  1  reset, asynchronous, active-low
- SC_GAMESEQ_Start_InLow  in  1  raw start pushbutton, active-low, asynchronous
- SC_GAMESEQ_FrogAtGoal_InHigh  in  1  frog occupies goal row (level)
- SC_GAMESEQ_Collision_InHigh  in  1  frog overlaps hazard (level)
- SC_GAMESEQ_Level_InBus  in  LEVEL_DATAWIDTH  current level from level counter
- SC_GAMESEQ_CurrentState_OutBus  out  STATE_DATAWIDTH  0 AWAITSTART, 1 STARTGAME, 2 ENDGAME
- SC_GAMESEQ_LevelUp_OutLow  out  1  one-cycle active-low level-advance pulse
- SC_GAMESEQ_Lives_OutBus  out  LIVES_DATAWIDTH  remaining lives
- SC_GAMESEQ_FrogReset_OutHigh  out  1  one-cycle pulse returning frog to start row
- SC_GAMESEQ_Win_OutHigh  out  1  high in ENDGAME if reached via final goal

## Operation

- Start input: 2-flop synchronizer, then falling-edge detect -> StartPress (one cycle per press).
- Goal/collision: registered, rising-edge detect -> GoalEvt, HitEvt.
- Internal FSM: IDLE, PLAY, HOLDOFF, OVER. Public code: IDLE=0; PLAY, HOLDOFF=1; OVER=2. Code 3 never driven.
- IDLE: StartPress -> PLAY; Lives <= INIT_LIVES, Win <= 0, FrogReset pulse.
- PLAY, HitEvt: Lives==1 -> OVER, Lives <= 0, Win <= 0; else Lives-1, FrogReset pulse, -> HOLDOFF.
- PLAY, GoalEvt (no HitEvt): Level_InBus==MAX_LEVEL-1 -> OVER, Win <= 1, no LevelUp pulse; else LevelUp pulse + FrogReset pulse, stay PLAY.
- HitEvt and GoalEvt same cycle: collision wins; goal ignored.
- HOLDOFF: counts HOLDOFF_CYCLES, ignores goal/collision/start, then -> PLAY. Counter cleared on entry.
- OVER: StartPress -> IDLE. Lives, Win held until leaving OVER.
- StartPress in PLAY/HOLDOFF ignored.
- Level/goal held high never re-triggers; needs deassert then reassert.
- Lives never underflow; decrement only from nonzero.

## Timing

- Reset (async assert, sync-to-clock release via normal flop behaviour): state IDLE, CurrentState=0, LevelUp_OutLow=1, Lives=0, FrogReset=0, Win=0, synchronizer flops=1 (button released), edge registers=0, hold-off counter=0.
- Start press to CurrentState change: 4 clock edges (2 sync, 1 edge, 1 state reg).
- Goal/collision input to LevelUp/FrogReset/state output: 2 edges (input reg, output reg).
- LevelUp_OutLow low for exactly one cycle per accepted goal; level counter sees it while CurrentState=1.
- HOLDOFF lasts exactly HOLDOFF_CYCLES cycles in code 1 before events accepted again.
- Reset mid-game: immediate return to IDLE; pending pulses dropped.

## Structure

- Shared package: game-state codes (AWAITSTART=0, STARTGAME=1, ENDGAME=2), STATE_DATAWIDTH, LEVEL_DATAWIDTH; same constants used by the level counter.
- Internal FSM encoding stays local.
- One sub-module: sc_gamesequencer_btnsync (2-flop sync + falling-edge detect, active-low reset to 1).

## Test plan

- Reset low mid-PLAY -> CurrentState=0, Lives=0, LevelUp_OutLow=1 at once, asynchronously.
- Start press from IDLE -> CurrentState=1 after 4 edges, Lives=3, one FrogReset pulse.
- Level_InBus=1, goal rising -> one-cycle LevelUp_OutLow=0, FrogReset pulse; goal held 10 cycles -> no second pulse.
- Level_InBus=3, goal rising -> CurrentState=2, Win=1, LevelUp_OutLow stays 1.
- Three collisions (HOLDOFF_CYCLES=8) -> Lives 3->2->1->0, 8-cycle HOLDOFF ignoring a collision, third hit -> CurrentState=2, Win=0; start -> CurrentState=0.
- Goal and collision rise same cycle with Lives=2 -> Lives=1, HOLDOFF, no LevelUp pulse.
